// File: rtl/cp0_regs.sv
// cp0_regs: M-stage CP0 holding SR/Cause/EPC/PRId, arbitrating interrupts vs. exceptions; define CP0_TIMER_EN to add Count/Compare timer on IP7
module cp0_regs #(
    parameter logic [31:0] PRID    = 32'h0017_3701,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PCM,
    input  logic        BDM,
    input  logic        ExceptionM,
    input  logic [4:0]  ExcM,
    input  logic [5:0]  HWInt,
    input  logic        EretM,
    output logic [31:0] DOut,
    output logic [31:0] EPC,
    output logic [31:0] Vector,
    output logic        IntReq
);
    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [29:0] epc_q;
    logic [5:0]  hw_eff;
    logic        irq_pend;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        unused_bits;

    assign wr_sr       = We && A == 5'd12;
    assign wr_epc      = We && A == 5'd14;
    assign irq_pend    = |(hw_eff & sr_im) & sr_ie & ~sr_exl;
    assign IntReq      = irq_pend | (ExceptionM & ~sr_exl);
    assign EPC         = {epc_q, 2'b00};
    assign Vector      = HANDLER;
    assign sr_val      = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_val   = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b00};
    assign unused_bits = &{1'b0, PCM[1:0], DIn[31:16], DIn[9:2]};

`ifdef CP0_TIMER_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_irq;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = We && A == 5'd9;
    assign wr_compare = We && A == 5'd11;
    assign hw_eff     = HWInt | {timer_irq, 5'b0};

    // free-running Count, Compare match raises the timer line until Compare is rewritten
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            compare   <= '0;
            timer_irq <= 1'b0;
        end else begin
            count <= wr_count ? DIn : count + 32'd1;
            if (wr_compare)
                compare <= DIn;
            if (wr_compare)
                timer_irq <= 1'b0;
            else if (!wr_count && count + 32'd1 == compare)
                timer_irq <= 1'b1;
        end
    end
`else
    assign hw_eff = HWInt;
`endif

    // exception entry beats eret, which beats mtc0; eret's EXL clear overrides a same-cycle SR write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc_q     <= '0;
        end else begin
            cause_ip <= hw_eff;
            if (IntReq) begin
                sr_exl    <= 1'b1;
                cause_bd  <= BDM;
                epc_q     <= PCM[31:2] - {29'b0, BDM};
                cause_exc <= irq_pend ? 5'd0 : ExcM;
            end else begin
                if (wr_sr) begin
                    sr_im  <= DIn[15:10];
                    sr_exl <= DIn[1];
                    sr_ie  <= DIn[0];
                end
                if (wr_epc)
                    epc_q <= DIn[31:2];
                if (EretM)
                    sr_exl <= 1'b0;
            end
        end
    end

    // mfc0 read mux; no bypass of a same-cycle mtc0
    always_comb begin
        DOut = '0;
        case (A)
            5'd12: DOut = sr_val;
            5'd13: DOut = cause_val;
            5'd14: DOut = EPC;
            5'd15: DOut = PRID;
`ifdef CP0_TIMER_EN
            5'd9:  DOut = count;
            5'd11: DOut = compare;
`endif
            default: DOut = '0;
        endcase
    end
endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 block in the M stage; consumes ExceptionM/ExcM from the E->M exception pipeline register.
- Holds SR(12), Cause(13), EPC(14) and PRId(15).
- Arbitrates hardware interrupts against synchronous exceptions, raises IntReq to flush the pipeline and redirect PC to the handler, and supplies EPC for eret.

Parameters:
- PRID, 32'h0017_3701, read-only value returned for register 15.
- HANDLER, 32'h0000_4180, exception vector, output on Vector for PC redirect.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; clears state immediately.
- A  in  5  mfc0/mtc0 register number.
- DIn  in  32  mtc0 write data.
- We  in  1  mtc0 write enable, M stage.
- PCM  in  32  PC of the M-stage instruction, word aligned.
- BDM  in  1  M-stage instruction sits in a branch delay slot.
- ExceptionM  in  1  synchronous exception pending in M.
- ExcM  in  5  exception code: 4 AdEL, 5 AdES, 10 RI, 12 Ov.
- HWInt  in  6  device interrupt lines, level sensitive.
- EretM  in  1  eret in M.
- DOut  out  32  combinational read of register A.
- EPC  out  32  registered EPC.
- Vector  out  32  constant HANDLER.
- IntReq  out  1  combinational "take exception/interrupt now".

Behaviour:
- Register fields:
  - SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause: BD[31], IP[15:10] (updated every cycle from HWInt), ExcCode[6:2]; all other bits read 0.
  - Unimplemented register numbers read 0; writes to them are ignored.
- Reset (reset=0, asynchronous): SR=0, Cause=0, EPC=0. IntReq, DOut and EPC follow from the cleared state.
- Interrupt/exception request:
  - IrqPend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - IntReq = IrqPend | (ExceptionM & ~SR.EXL); purely combinational, same cycle.
- On the posedge with IntReq=1:
  - SR.EXL<=1.
  - Cause.BD<=BDM.
  - EPC<= BDM ? PCM-4 : PCM.
  - Cause.ExcCode<= IrqPend ? 0 : ExcM.
  - Interrupt has priority over a simultaneous exception.
- Write priority for SR/Cause/EPC: IntReq > EretM > We.
  - If IntReq and We coincide, the write is discarded.
  - EretM: SR.EXL<=0.
  - If EretM and We target SR in the same cycle, the eret clear wins for EXL; all other SR bits take DIn.
- mtc0 writable fields:
  - SR: IM, EXL, IE.
  - EPC: bits [31:2]; [1:0] forced 0.
  - Cause: no writable fields; writes are ignored.
  - PRId: writes ignored.
- Read path: no bypass. mfc0 in the same cycle as mtc0 to the same register returns the old value; the new value is visible the next cycle.
- Nested events: while EXL=1, no new exception or interrupt is taken. ExceptionM is ignored (handler errors are undefined). HWInt stays pending in Cause.IP.
- EPC arithmetic is 32-bit modulo. PCM=0 with BDM=1 yields 32'hFFFF_FFFC.

Optional Feature:
- Macro: CP0_TIMER_EN.
- With the macro:
  - Adds Count (reg 9) and Compare (reg 11), both reset 0.
  - Count increments every cycle and wraps at 2^32.
  - mtc0 to Count loads DIn, and DIn is the Count value seen that cycle; the increment resumes the next cycle.
  - A write to Compare clears TimerIrq.
  - TimerIrq sets when Count==Compare after the increment, and is ORed into HWInt[5] (IP7).
- Without the macro: regs 9 and 11 read 0, no timer logic is built, and HWInt[5] comes from the port only.

Test Plan:
- Reset: assert reset=0 mid-cycle -> SR, Cause and EPC read 0 immediately; IntReq=0 even with HWInt=6'h3F.
- Interrupt:
  - Setup: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), then HWInt=6'b000001 with PCM=32'h0000_3010, BDM=0.
  - Expected: IntReq=1 the same cycle; next cycle EPC=32'h3010, Cause.ExcCode=0, SR=32'h0403.
- Exception in delay slot: ExceptionM=1, ExcM=12, BDM=1, PCM=32'h3024 -> EPC=32'h3020, Cause=32'h8000_0030.
- Simultaneous events:
  - Interrupt + exception (ExcM=10) in one cycle -> ExcCode=0.
  - Same cycle We=1, A=14, DIn=32'h1234 -> EPC=PCM, not 32'h1234.
- eret and masking:
  - With EXL=1, raise ExceptionM=1 -> IntReq=0.
  - Then EretM=1 -> EXL=0 next cycle; with HWInt still pending and unmasked, IntReq=1 the following cycle.
- CP0_TIMER_EN: mtc0 Compare=5, Count=0 -> TimerIrq sets 5 cycles after the Count write; a Compare rewrite clears it.
